load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: decodes size/alignment, drives a single-beat word bus,
// extends load data and aborts on misalignment or bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_valid,
    input  logic        I_memrw,
    input  logic [2:0]  I_loadsel,
    input  logic [1:0]  I_storesel,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    output logic        O_stall,
    output logic        O_done,
    output logic [31:0] O_rdata,
    output logic        O_misalign,
    output logic        O_timeout,
    output logic        O_bus_req,
    output logic        O_bus_we,
    output logic [31:0] O_bus_addr,
    output logic [31:0] O_bus_wdata,
    output logic [3:0]  O_bus_be,
    input  logic        I_bus_ack,
    input  logic [31:0] I_bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Last BUSY cycle index before the access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        tmo_q, tmo_d;

    logic [1:0]  req_size;
    logic        req_uns;
    logic        req_illegal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] lane;
    logic [31:0] ld_ext;

    // State and access registers; reset clears everything, aborting any access.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // Decode the incoming request: size 00/01/10 = byte/half/word.
    always_comb begin
        req_size    = I_memrw ? I_storesel : I_loadsel[1:0];
        req_uns     = ~I_memrw & I_loadsel[2];
        req_illegal = 1'b0;
        if (req_size == 2'b11) begin
            req_illegal = 1'b1;
        end
        if (!I_memrw && I_loadsel[2] && I_loadsel[1]) begin
            req_illegal = 1'b1;
        end
        if (req_size == 2'b01 && I_addr[0]) begin
            req_illegal = 1'b1;
        end
        if (req_size == 2'b10 && I_addr[1:0] != 2'b00) begin
            req_illegal = 1'b1;
        end
        case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << I_addr[1:0];
                req_wdata = {4{I_wdata[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << I_addr[1:0];
                req_wdata = {2{I_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = I_wdata;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        lane   = I_bus_rdata >> {addr_q[1:0], 3'b000};
        ld_ext = lane;
        case (size_q)
            2'b00: ld_ext = uns_q ? {24'h0, lane[7:0]}
                                  : {{24{lane[7]}}, lane[7:0]};
            2'b01: ld_ext = uns_q ? {16'h0, lane[15:0]}
                                  : {{16{lane[15]}}, lane[15:0]};
            default: ld_ext = lane;
        endcase
        if (we_q) begin
            ld_ext = '0;
        end
    end

    // Access sequencing: accept, wait for ack or timeout, report for one cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (I_valid) begin
                    addr_d  = I_addr;
                    we_d    = I_memrw;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (req_illegal) begin
                        state_d = S_ERR;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (I_bus_ack) begin
                    state_d = S_DONE;
                    rdata_d = ld_ext;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign O_stall     = (state_q == S_IDLE) ? I_valid : (state_q == S_BUSY);
    assign O_done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign O_rdata     = rdata_q;
    assign O_misalign  = mis_q;
    assign O_timeout   = tmo_q;
    assign O_bus_req   = (state_q == S_BUSY);
    assign O_bus_we    = we_q;
    assign O_bus_addr  = {addr_q[31:2], 2'b00};
    assign O_bus_wdata = wdata_q;
    assign O_bus_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses
// compared against a byte-level behavioural model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_valid = 1'b0;
    logic        I_memrw = 1'b0;
    logic [2:0]  I_loadsel = '0;
    logic [1:0]  I_storesel = '0;
    logic [31:0] I_addr = '0;
    logic [31:0] I_wdata = '0;
    logic        O_stall, O_done, O_misalign, O_timeout;
    logic [31:0] O_rdata;
    logic        O_bus_req, O_bus_we;
    logic [31:0] O_bus_addr, O_bus_wdata;
    logic [3:0]  O_bus_be;
    logic        I_bus_ack = 1'b0;
    logic [31:0] I_bus_rdata = '0;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n),
        .I_valid(I_valid), .I_memrw(I_memrw),
        .I_loadsel(I_loadsel), .I_storesel(I_storesel),
        .I_addr(I_addr), .I_wdata(I_wdata),
        .O_stall(O_stall), .O_done(O_done), .O_rdata(O_rdata),
        .O_misalign(O_misalign), .O_timeout(O_timeout),
        .O_bus_req(O_bus_req), .O_bus_we(O_bus_we),
        .O_bus_addr(O_bus_addr), .O_bus_wdata(O_bus_wdata),
        .O_bus_be(O_bus_be), .I_bus_ack(I_bus_ack),
        .I_bus_rdata(I_bus_rdata)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    // Observations collected by do_access
    logic [3:0]  ob_be;
    logic [31:0] ob_addr, ob_wdata, ob_rdata;
    logic        ob_we, ob_mis, ob_tmo, ob_done_seen;
    logic        ob_unstable, ob_idle_req, ob_done_after;
    int          ob_req, ob_stall, ob_done_cyc, ob_t_start, ob_t_done;

    // Model: byte-granular view of the access rules.
    function automatic void ref_model(
        input logic rw, input logic [2:0] ls, input logic [1:0] ss,
        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
        output logic legal, output logic [3:0] be,
        output logic [31:0] bw, output logic [31:0] res);
        int n, off;
        bit sgn;
        longint v;
        n = 0; sgn = 0; v = 0;
        off = int'(a % 32'd4);
        if (rw) begin
            n = (ss == 2'd0) ? 1 : (ss == 2'd1) ? 2 : (ss == 2'd2) ? 4 : 0;
        end else begin
            case (ls)
                3'b000: begin n = 1; sgn = 1; end
                3'b001: begin n = 2; sgn = 1; end
                3'b010: n = 4;
                3'b100: n = 1;
                3'b101: n = 2;
                default: n = 0;
            endcase
        end
        legal = 1'b0;
        if (n != 0) legal = ((off % n) == 0);
        be = '0; bw = '0; res = '0;
        if (n != 0) begin
            for (int i = 0; i < 4; i++) begin
                be[i] = (i >= off) && (i < off + n);
                bw[8*i +: 8] = wd[8*(i % n) +: 8];
            end
        end
        if (legal && !rw) begin
            for (int k = 0; k < n; k++)
                v += longint'(rd[8*(off+k) +: 8]) << (8*k);
            if (sgn && v >= (longint'(1) << (8*n-1)))
                v -= (longint'(1) << (8*n));
            res = v[31:0];
        end
    endfunction

    // Drive one access; ack_wait = BUSY cycles before ack (-1 = never).
    task automatic do_access(input logic rw, input logic [2:0] ls,
                             input logic [1:0] ss, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_wait,
                             input logic [31:0] brd);
        int cycle, bi;
        ob_be = '0; ob_addr = '0; ob_wdata = '0; ob_rdata = '0;
        ob_we = 0; ob_mis = 0; ob_tmo = 0; ob_done_seen = 0;
        ob_unstable = 0; ob_idle_req = 0; ob_done_after = 0;
        ob_req = 0; ob_stall = 0; ob_done_cyc = 0; ob_t_done = 0;
        @(negedge I_clk);
        I_valid = 1; I_memrw = rw; I_loadsel = ls; I_storesel = ss;
        I_addr = a; I_wdata = wd; I_bus_rdata = brd;
        ob_t_start = cyc;
        #1;
        if (O_stall) ob_stall++;
        if (O_bus_req || O_done) ob_idle_req = 1;
        @(posedge I_clk);
        #1;
        I_valid = 0; I_addr = $urandom; I_wdata = $urandom;
        I_loadsel = 3'($urandom); I_storesel = 2'($urandom);
        cycle = 1; bi = 0;
        while (!ob_done_seen && cycle < 300) begin
            @(negedge I_clk);
            cycle++;
            if (O_stall) ob_stall++;
            if (O_bus_req) begin
                if (bi == 0) begin
                    ob_be = O_bus_be; ob_addr = O_bus_addr;
                    ob_wdata = O_bus_wdata; ob_we = O_bus_we;
                end else if (ob_be !== O_bus_be || ob_addr !== O_bus_addr ||
                             ob_wdata !== O_bus_wdata || ob_we !== O_bus_we) begin
                    ob_unstable = 1;
                end
                ob_req++;
                I_bus_ack = (bi == ack_wait);
                bi++;
            end
            if (O_done) begin
                ob_done_seen = 1; ob_done_cyc = cycle; ob_t_done = cyc;
                ob_rdata = O_rdata; ob_mis = O_misalign; ob_tmo = O_timeout;
            end
            @(posedge I_clk);
            #1;
            I_bus_ack = 0;
        end
        ob_done_after = O_done;
    endtask

    task automatic test_reset();
        logic bad;
        I_rst_n = 0;
        repeat (2) @(negedge I_clk);
        n_checks++;
        if ({O_bus_req, O_done, O_misalign, O_timeout, O_stall, O_bus_we} !== 6'b0) begin
            $display("FAIL reset_flags got=%b want=000000",
                     {O_bus_req, O_done, O_misalign, O_timeout, O_stall, O_bus_we});
        end else n_pass++;
        n_checks++;
        if ({O_rdata, O_bus_addr, O_bus_wdata, O_bus_be} !== '0) begin
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b want all 0",
                     O_rdata, O_bus_addr, O_bus_wdata, O_bus_be);
        end else n_pass++;
        I_rst_n = 1;
        bad = 0;
        I_bus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge I_clk);
            I_bus_ack = 1;
            if (O_bus_req || O_done || O_misalign || O_timeout || O_stall) bad = 1;
        end
        @(negedge I_clk);
        I_bus_ack = 0;
        n_checks++;
        if (bad || O_done || O_rdata !== 32'h0) begin
            $display("FAIL idle_ack_ignored bad=%0d done=%b rdata=%h want 0/0/0",
                     bad, O_done, O_rdata);
        end else n_pass++;
    endtask

    task automatic test_lb_sign();
        do_access(1'b0, 3'b000, 2'b00, 32'h1003, 32'h0, 0, 32'h80FF_FF12);
        n_checks++;
        if (ob_be !== 4'b1000 || ob_rdata !== 32'hFFFF_FF80) begin
            $display("FAIL lb_data be=%b rdata=%h want 1000 ffffff80", ob_be, ob_rdata);
        end else n_pass++;
        n_checks++;
        if (ob_done_cyc != 3 || ob_done_after || ob_mis || ob_tmo) begin
            $display("FAIL lb_timing done_cyc=%0d after=%b mis=%b tmo=%b want 3/0/0/0",
                     ob_done_cyc, ob_done_after, ob_mis, ob_tmo);
        end else n_pass++;
    endtask

    task automatic test_sh_wait();
        do_access(1'b1, 3'b000, 2'b01, 32'h2002, 32'h0000_BEEF, 3, 32'h1234_5678);
        n_checks++;
        if (ob_addr !== 32'h2000 || ob_be !== 4'b1100 || ob_wdata !== 32'hBEEF_BEEF || !ob_we) begin
            $display("FAIL sh_bus addr=%h be=%b wdata=%h we=%b want 2000 1100 beefbeef 1",
                     ob_addr, ob_be, ob_wdata, ob_we);
        end else n_pass++;
        n_checks++;
        if (ob_stall != 5 || ob_req != 4 || ob_rdata !== 32'h0 || ob_unstable) begin
            $display("FAIL sh_stall stall=%0d req=%0d rdata=%h unstable=%b want 5 4 0 0",
                     ob_stall, ob_req, ob_rdata, ob_unstable);
        end else n_pass++;
    endtask

    task automatic test_misalign();
        do_access(1'b0, 3'b010, 2'b00, 32'h0005, 32'h0, 0, 32'hFFFF_FFFF);
        n_checks++;
        if (ob_req != 0 || ob_done_cyc != 2 || !ob_mis || ob_tmo || ob_rdata !== 32'h0) begin
            $display("FAIL lw_misalign req=%0d done_cyc=%0d mis=%b tmo=%b rdata=%h want 0 2 1 0 0",
                     ob_req, ob_done_cyc, ob_mis, ob_tmo, ob_rdata);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        do_access(1'b0, 3'b101, 2'b00, 32'h0002, 32'h0, -1, 32'hAAAA_5555);
        n_checks++;
        if (ob_req != TO || ob_done_cyc != TO + 2 || !ob_tmo || ob_mis) begin
            $display("FAIL lhu_timeout req=%0d done_cyc=%0d tmo=%b mis=%b want %0d %0d 1 0",
                     ob_req, ob_done_cyc, ob_tmo, ob_mis, TO, TO + 2);
        end else n_pass++;
        n_checks++;
        if (ob_done_after || ob_rdata !== 32'h0 || ob_be !== 4'b1100) begin
            $display("FAIL lhu_timeout_tail after=%b rdata=%h be=%b want 0 0 1100",
                     ob_done_after, ob_rdata, ob_be);
        end else n_pass++;
    endtask

    task automatic test_reset_busy();
        logic seen;
        @(negedge I_clk);
        I_valid = 1; I_memrw = 1; I_storesel = 2'b10;
        I_addr = 32'h100; I_wdata = 32'hCAFE_F00D;
        @(posedge I_clk);
        #1;
        I_valid = 0;
        @(negedge I_clk);
        n_checks++;
        if (O_bus_req !== 1'b1) begin
            $display("FAIL sw_busy_req got=%b want 1", O_bus_req);
        end else n_pass++;
        I_rst_n = 0;
        #1;
        n_checks++;
        if (O_bus_req !== 1'b0 || O_stall !== 1'b0 || O_bus_be !== 4'b0) begin
            $display("FAIL rst_mid_busy req=%b stall=%b be=%b want 0 0 0",
                     O_bus_req, O_stall, O_bus_be);
        end else n_pass++;
        @(negedge I_clk);
        I_rst_n = 1;
        I_bus_ack = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge I_clk);
            if (O_done || O_bus_req) seen = 1;
        end
        I_bus_ack = 0;
        n_checks++;
        if (seen) begin
            $display("FAIL rst_no_done got=done/req seen want none");
        end else n_pass++;
        do_access(1'b1, 3'b000, 2'b10, 32'h104, 32'h0102_0304, 0, 32'h0);
        n_checks++;
        if (ob_done_cyc != 3 || ob_be !== 4'b1111 || ob_wdata !== 32'h0102_0304) begin
            $display("FAIL sw_after_rst done_cyc=%0d be=%b wdata=%h want 3 1111 01020304",
                     ob_done_cyc, ob_be, ob_wdata);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t_done1;
        do_access(1'b0, 3'b100, 2'b00, 32'h10, 32'h0, 0, 32'h0000_00F0);
        t_done1 = ob_t_done;
        n_checks++;
        if (ob_rdata !== 32'h0000_00F0 || ob_done_cyc != 3) begin
            $display("FAIL lbu_b2b rdata=%h done_cyc=%0d want 000000f0 3",
                     ob_rdata, ob_done_cyc);
        end else n_pass++;
        do_access(1'b1, 3'b000, 2'b00, 32'h11, 32'h0000_00A5, 0, 32'h0);
        n_checks++;
        if (ob_t_start != t_done1 + 1 || ob_stall != 2 || ob_done_cyc != 3) begin
            $display("FAIL sb_b2b start=%0d want=%0d stall=%0d done_cyc=%0d want 2 3",
                     ob_t_start, t_done1 + 1, ob_stall, ob_done_cyc);
        end else n_pass++;
        n_checks++;
        if (ob_be !== 4'b0010 || ob_wdata !== 32'hA5A5_A5A5) begin
            $display("FAIL sb_b2b_bus be=%b wdata=%h want 0010 a5a5a5a5", ob_be, ob_wdata);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic rw, legal;
        logic [2:0] ls;
        logic [1:0] ss;
        logic [31:0] a, wd, rd, e_bw, e_res;
        logic [3:0] e_be;
        int w;
        for (int it = 0; it < 40; it++) begin
            rw = 1'($urandom); ls = 3'($urandom); ss = 2'($urandom);
            a = $urandom; wd = $urandom; rd = $urandom;
            w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
            ref_model(rw, ls, ss, a, wd, rd, legal, e_be, e_bw, e_res);
            do_access(rw, ls, ss, a, wd, w, rd);
            n_checks++;
            if (ob_idle_req || ob_done_after || ob_unstable || !ob_done_seen) begin
                $display("FAIL rnd%0d_proto idle_req=%b after=%b unstable=%b done=%b",
                         it, ob_idle_req, ob_done_after, ob_unstable, ob_done_seen);
            end else n_pass++;
            if (!legal) begin
                n_checks++;
                if (ob_req != 0 || !ob_mis || ob_tmo || ob_rdata !== 0 || ob_done_cyc != 2) begin
                    $display("FAIL rnd%0d_illegal req=%0d mis=%b tmo=%b rdata=%h cyc=%0d",
                             it, ob_req, ob_mis, ob_tmo, ob_rdata, ob_done_cyc);
                end else n_pass++;
                continue;
            end
            n_checks++;
            if (ob_be !== e_be || ob_addr !== {a[31:2], 2'b00} || ob_we !== rw) begin
                $display("FAIL rnd%0d_bus be=%b/%b addr=%h/%h we=%b/%b",
                         it, ob_be, e_be, ob_addr, {a[31:2], 2'b00}, ob_we, rw);
            end else n_pass++;
            if (rw) begin
                n_checks++;
                if (ob_wdata !== e_bw) begin
                    $display("FAIL rnd%0d_wdata got=%h want=%h", it, ob_wdata, e_bw);
                end else n_pass++;
            end
            n_checks++;
            if (w >= TO) begin
                if (ob_req != TO || !ob_tmo || ob_mis || ob_rdata !== 0) begin
                    $display("FAIL rnd%0d_tmo req=%0d tmo=%b mis=%b rdata=%h want %0d 1 0 0",
                             it, ob_req, ob_tmo, ob_mis, ob_rdata, TO);
                end else n_pass++;
            end else begin
                if (ob_req != w + 1 || ob_done_cyc != w + 3 || ob_tmo || ob_mis ||
                    ob_rdata !== e_res) begin
                    $display("FAIL rnd%0d_ok req=%0d cyc=%0d tmo=%b mis=%b rdata=%h want %0d %0d 0 0 %h",
                             it, ob_req, ob_done_cyc, ob_tmo, ob_mis, ob_rdata,
                             w + 1, w + 3, e_res);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_wait();
        test_misalign();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
